// File: rtl/err_backprop.sv
// Error back-propagation stage: computes (prediction - label) >>> lr_shift, saturates it,
// tags batch boundaries and buffers the result in a small FIFO toward the weight-update engine.
module err_backprop #(
  parameter int bitwidth   = 8,
  parameter int fifo_depth = 4,
  parameter int lr_shift   = 2,
  parameter int batch_size = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bitwidth-1:0] pred_in,
  input  logic [bitwidth-1:0] label_in,
  input  logic                pred_valid,
  output logic                in_ready,
  output logic [bitwidth-1:0] err_out,
  output logic                err_last,
  output logic                err_valid,
  input  logic                err_ready
);

  localparam int aw    = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cnt_w = aw + 1;
  localparam int cw    = (batch_size > 1) ? $clog2(batch_size) : 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);
  localparam logic [cw-1:0]    last_c  = cw'(batch_size - 1);

  logic signed [bitwidth:0] diff;
  logic signed [bitwidth:0] scaled;
  logic [bitwidth-1:0]      err_sat;

  logic [bitwidth:0]  mem [fifo_depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic [cnt_w-1:0]   count;
  logic [cw-1:0]      batch_cnt;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               is_last;
  logic [bitwidth:0]  head;

  // The top two bits of the shifted value disagree only when it falls outside the signed range.
  always_comb begin
    diff    = $signed({1'b0, pred_in}) - $signed({1'b0, label_in});
    scaled  = diff >>> lr_shift;
    err_sat = scaled[bitwidth-1:0];
    if (scaled[bitwidth] != scaled[bitwidth-1]) begin
      err_sat = scaled[bitwidth] ? {1'b1, {(bitwidth-1){1'b0}}}
                                 : {1'b0, {(bitwidth-1){1'b1}}};
    end
  end

  assign full     = (count == depth_c);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = pred_valid && !full;
  assign pop      = err_ready && !empty;
  assign is_last  = (batch_cnt == last_c);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {is_last, err_sat};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      batch_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        batch_cnt <= is_last ? '0 : batch_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign err_valid = !empty;
  assign err_out   = empty ? '0 : head[bitwidth-1:0];
  assign err_last  = empty ? 1'b0 : head[bitwidth];

endmodule

// File: tb/tb_err_backprop.sv
// Directed bench for err_backprop: default instance plus an lr_shift=0 instance sharing inputs.
module tb_err_backprop;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pred_in;
  logic [7:0] label_in;
  logic       pred_valid;
  logic       err_ready;

  logic       in_ready,  err_last,  err_valid;
  logic [7:0] err_out;
  logic       s_in_ready, s_err_last, s_err_valid;
  logic [7:0] s_err_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  err_backprop dut (
    .clk(clk), .rst(rst), .pred_in(pred_in), .label_in(label_in),
    .pred_valid(pred_valid), .in_ready(in_ready), .err_out(err_out),
    .err_last(err_last), .err_valid(err_valid), .err_ready(err_ready)
  );

  err_backprop #(.bitwidth(8), .fifo_depth(4), .lr_shift(0), .batch_size(3)) dut_sat (
    .clk(clk), .rst(rst), .pred_in(pred_in), .label_in(label_in),
    .pred_valid(pred_valid), .in_ready(s_in_ready), .err_out(s_err_out),
    .err_last(s_err_last), .err_valid(s_err_valid), .err_ready(err_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pred_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] p, input logic [7:0] l);
    pred_in    = p;
    label_in   = l;
    pred_valid = 1'b1;
    tick();
    pred_valid = 1'b0;
  endtask

  logic [7:0] exp_err [5];
  logic       exp_last [5];

  initial begin
    rst = 1'b1; pred_in = '0; label_in = '0; pred_valid = 1'b0; err_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_valid", err_valid, 0);
    check("rst_out",   err_out,   0);
    check("rst_last",  err_last,  0);
    check("rst_ready", in_ready,  1);

    // scaling and sign handling
    err_ready = 1'b1;
    push(200, 100);
    check("scale_valid", err_valid, 1);
    check("scale_out",   err_out,   8'h19);
    check("scale_last",  err_last,  0);
    check("scale_sat_inst", s_err_out, 8'h64);
    tick();
    check("scale_popped", err_valid, 0);
    push(10, 250);
    check("neg_out", err_out, 8'hC4);
    tick();
    do_reset();
    push(5, 5);
    check("zero_out", err_out, 8'h00);
    push(3, 0);
    check("trunc_pos", err_out, 8'h00);
    push(0, 1);
    check("trunc_neg", err_out, 8'hFF);
    check("trunc_neg_last", err_last, 1);
    tick();

    // saturation on the lr_shift=0 instance
    do_reset();
    push(255, 0);
    check("sat_pos", s_err_out, 8'h7F);
    push(0, 255);
    check("sat_neg", s_err_out, 8'h80);
    push(0, 128);
    check("sat_edge", s_err_out, 8'h80);
    tick();

    // fill, backpressure, single pop, then the held sample enters
    do_reset();
    err_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_err[i]  = 8'(25 + i);
      exp_last[i] = (i == 2);
    end
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", in_ready, 1);
      push(8'(100 + 4 * i), 0);
    end
    check("full_ready", in_ready, 0);
    check("full_head",  err_out,  exp_err[0]);
    pred_in = 116; label_in = 0; pred_valid = 1'b1;
    tick();
    check("held_ready", in_ready, 0);
    check("held_stable", err_out, exp_err[0]);
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    check("one_pop_ready", in_ready, 1);
    check("one_pop_head",  err_out,  exp_err[1]);
    tick();
    pred_valid = 1'b0;
    check("fifth_taken", in_ready, 0);
    err_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("drain_valid", err_valid, 1);
      check("drain_out",   err_out,   exp_err[i]);
      check("drain_last",  err_last,  exp_last[i]);
      tick();
    end
    check("drain_empty", err_valid, 0);

    // batch tagging over 7 streamed samples
    do_reset();
    err_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pred_in = 8'(8 * (i + 1)); label_in = 0; pred_valid = 1'b1;
      tick();
      check("batch_out",  err_out,  32'(2 * (i + 1)));
      check("batch_last", err_last, (i == 2 || i == 5) ? 1 : 0);
    end
    pred_valid = 1'b0;
    tick();

    // reset with data buffered and batch counter at 2
    do_reset();
    err_ready = 1'b0;
    push(40, 0);
    push(44, 0);
    check("pre_rst_valid", err_valid, 1);
    pred_in = 48; label_in = 0; pred_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; pred_valid = 1'b0;
    check("mid_rst_valid", err_valid, 0);
    check("mid_rst_out",   err_out,   0);
    check("mid_rst_last",  err_last,  0);
    check("mid_rst_ready", in_ready,  1);
    tick();
    check("rst_input_dropped", err_valid, 0);
    err_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pred_in = 8'(4 * (i + 1)); label_in = 0; pred_valid = 1'b1;
      tick();
      check("restart_out",  err_out,  32'(i + 1));
      check("restart_last", err_last, (i == 2) ? 1 : 0);
    end
    pred_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
